sid_regbank: RTL and testbench

CPU-facing configuration and sequencing front end for the three-voice SID channel datapath and the filter/mixer.
- Decodes a byte-wide register bus onto the SID register map (0x00–0x1C) and holds every voice/filter configuration field.
- Provides readback of OSC3, ENV3 and the POT registers.
- Generates the datapath clock enable (nominal 1 MHz tick) from the system clock.
- Owns the only writable copy of the voice configuration; the channel datapath consumes its outputs combinationally.

---
 rtl/sid_regbank.sv | 194 +++++++++++++++++++
 tb/tb_sid_regbank.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sid_regbank.sv
// SID register bank: byte-bus decode onto the voice/filter register map,
// OSC3/ENV3/POT readback, and the datapath clock-enable divider.
module sid_regbank #(
   parameter int unsigned CLK_DIV     = 25,
   parameter logic [7:0]  POT_DEFAULT = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  bus_addr,
   input  logic [7:0]  bus_wdata,
   input  logic        bus_we,
   input  logic        bus_re,
   output logic [7:0]  bus_rdata,
   output logic        bus_ack,
   input  logic [7:0]  osc3,
   input  logic [7:0]  ch3_env,
   output logic        clk_enable,
   output logic [15:0] freq1,
   output logic [15:0] freq2,
   output logic [15:0] freq3,
   output logic [11:0] pw1,
   output logic [11:0] pw2,
   output logic [11:0] pw3,
   output logic [7:0]  ctrl_reg1,
   output logic [7:0]  ctrl_reg2,
   output logic [7:0]  ctrl_reg3,
   output logic [7:0]  atk_dec1,
   output logic [7:0]  atk_dec2,
   output logic [7:0]  atk_dec3,
   output logic [7:0]  sus_rel1,
   output logic [7:0]  sus_rel2,
   output logic [7:0]  sus_rel3,
   output logic [10:0] fc,
   output logic [7:0]  res_filt,
   output logic [7:0]  mode_vol
);

   localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      F_NONE,
      F_FREQ_LO,
      F_FREQ_HI,
      F_PW_LO,
      F_PW_HI,
      F_CTRL,
      F_ATK_DEC,
      F_SUS_REL,
      F_FC_LO,
      F_FC_HI,
      F_RES_FILT,
      F_MODE_VOL
   } field_t;

   logic [15:0]   freq_r    [3];
   logic [11:0]   pw_r      [3];
   logic [7:0]    ctrl_r    [3];
   logic [7:0]    atk_dec_r [3];
   logic [7:0]    sus_rel_r [3];
   logic [10:0]   fc_r;
   logic [7:0]    res_filt_r;
   logic [7:0]    mode_vol_r;
   logic [7:0]    last_write;
   logic [7:0]    rdata_r;
   logic          ack_r;
   logic [CW-1:0] div_cnt;
   logic          ena_r;

   field_t        field;
   logic [1:0]    voice;
   logic [4:0]    offset;
   logic [7:0]    read_value;

   // Voice registers occupy 0x00-0x14 as three 7-byte blocks; split into voice/offset.
   always_comb begin
      voice  = 2'd0;
      offset = bus_addr;
      field  = F_NONE;
      if (bus_addr < 5'd7) begin
         voice  = 2'd0;
         offset = bus_addr;
      end else if (bus_addr < 5'd14) begin
         voice  = 2'd1;
         offset = bus_addr - 5'd7;
      end else if (bus_addr < 5'd21) begin
         voice  = 2'd2;
         offset = bus_addr - 5'd14;
      end
      if (bus_addr < 5'd21) begin
         case (offset)
            5'd0:    field = F_FREQ_LO;
            5'd1:    field = F_FREQ_HI;
            5'd2:    field = F_PW_LO;
            5'd3:    field = F_PW_HI;
            5'd4:    field = F_CTRL;
            5'd5:    field = F_ATK_DEC;
            5'd6:    field = F_SUS_REL;
            default: field = F_NONE;
         endcase
      end else begin
         case (bus_addr)
            5'h15:   field = F_FC_LO;
            5'h16:   field = F_FC_HI;
            5'h17:   field = F_RES_FILT;
            5'h18:   field = F_MODE_VOL;
            default: field = F_NONE;
         endcase
      end
   end

   // Write-only and unmapped addresses read back the last bus write (bus decay).
   always_comb begin
      case (bus_addr)
         5'h19, 5'h1A: read_value = POT_DEFAULT;
         5'h1B:        read_value = osc3;
         5'h1C:        read_value = ch3_env;
         default:      read_value = last_write;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned v = 0; v < 3; v++) begin
            freq_r[v]    <= '0;
            pw_r[v]      <= '0;
            ctrl_r[v]    <= '0;
            atk_dec_r[v] <= '0;
            sus_rel_r[v] <= '0;
         end
         fc_r       <= '0;
         res_filt_r <= '0;
         mode_vol_r <= '0;
         last_write <= '0;
         rdata_r    <= '0;
         ack_r      <= 1'b0;
      end else begin
         ack_r <= bus_we | bus_re;
         if (bus_we) begin
            last_write <= bus_wdata;
            case (field)
               F_FREQ_LO:  freq_r[voice][7:0]  <= bus_wdata;
               F_FREQ_HI:  freq_r[voice][15:8] <= bus_wdata;
               F_PW_LO:    pw_r[voice][7:0]    <= bus_wdata;
               F_PW_HI:    pw_r[voice][11:8]   <= bus_wdata[3:0];
               F_CTRL:     ctrl_r[voice]       <= bus_wdata;
               F_ATK_DEC:  atk_dec_r[voice]    <= bus_wdata;
               F_SUS_REL:  sus_rel_r[voice]    <= bus_wdata;
               F_FC_LO:    fc_r[2:0]           <= bus_wdata[2:0];
               F_FC_HI:    fc_r[10:3]          <= bus_wdata;
               F_RES_FILT: res_filt_r          <= bus_wdata;
               F_MODE_VOL: mode_vol_r          <= bus_wdata;
               default:    ;
            endcase
         end else if (bus_re) begin
            rdata_r <= read_value;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         ena_r   <= 1'b0;
      end else begin
         ena_r   <= (div_cnt == CNT_MAX);
         div_cnt <= (div_cnt == CNT_MAX) ? '0 : div_cnt + 1'b1;
      end
   end

   assign bus_rdata  = rdata_r;
   assign bus_ack    = ack_r;
   assign clk_enable = ena_r;

   assign freq1     = freq_r[0];
   assign freq2     = freq_r[1];
   assign freq3     = freq_r[2];
   assign pw1       = pw_r[0];
   assign pw2       = pw_r[1];
   assign pw3       = pw_r[2];
   assign ctrl_reg1 = ctrl_r[0];
   assign ctrl_reg2 = ctrl_r[1];
   assign ctrl_reg3 = ctrl_r[2];
   assign atk_dec1  = atk_dec_r[0];
   assign atk_dec2  = atk_dec_r[1];
   assign atk_dec3  = atk_dec_r[2];
   assign sus_rel1  = sus_rel_r[0];
   assign sus_rel2  = sus_rel_r[1];
   assign sus_rel3  = sus_rel_r[2];
   assign fc        = fc_r;
   assign res_filt  = res_filt_r;
   assign mode_vol  = mode_vol_r;

endmodule

// File: tb/tb_sid_regbank.sv
// Directed bench for sid_regbank: divider timing, register writes, readback,
// bus-decay reads, simultaneous read/write and reset-vs-access priority.
module tb_sid_regbank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  bus_addr = '0;
   logic [7:0]  bus_wdata = '0;
   logic        bus_we = 1'b0;
   logic        bus_re = 1'b0;
   logic [7:0]  bus_rdata;
   logic        bus_ack;
   logic [7:0]  osc3 = '0;
   logic [7:0]  ch3_env = '0;
   logic        clk_enable;
   logic [15:0] freq1, freq2, freq3;
   logic [11:0] pw1, pw2, pw3;
   logic [7:0]  ctrl_reg1, ctrl_reg2, ctrl_reg3;
   logic [7:0]  atk_dec1, atk_dec2, atk_dec3;
   logic [7:0]  sus_rel1, sus_rel2, sus_rel3;
   logic [10:0] fc;
   logic [7:0]  res_filt, mode_vol;

   int total = 0;
   int bad   = 0;

   sid_regbank #(.CLK_DIV(25), .POT_DEFAULT(8'hFF)) dut (
      .clk(clk), .rst(rst),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .osc3(osc3), .ch3_env(ch3_env), .clk_enable(clk_enable),
      .freq1(freq1), .freq2(freq2), .freq3(freq3),
      .pw1(pw1), .pw2(pw2), .pw3(pw3),
      .ctrl_reg1(ctrl_reg1), .ctrl_reg2(ctrl_reg2), .ctrl_reg3(ctrl_reg3),
      .atk_dec1(atk_dec1), .atk_dec2(atk_dec2), .atk_dec3(atk_dec3),
      .sus_rel1(sus_rel1), .sus_rel2(sus_rel2), .sus_rel3(sus_rel3),
      .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One-cycle write; afterwards outputs and ack reflect the write.
   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      bus_addr  = a;
      bus_wdata = d;
      bus_we    = 1'b1;
      tick();
      bus_we    = 1'b0;
      chk("wr_ack", 16'(bus_ack), 16'h1);
   endtask

   task automatic rd(input logic [4:0] a, input logic [7:0] expected, input string tag);
      bus_addr = a;
      bus_re   = 1'b1;
      tick();
      bus_re   = 1'b0;
      chk(tag, 16'(bus_rdata), 16'(expected));
      chk("rd_ack", 16'(bus_ack), 16'h1);
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_ack", 16'(bus_ack), 16'h0);
      chk("rst_rdata", 16'(bus_rdata), 16'h0);
      chk("rst_ena", 16'(clk_enable), 16'h0);

      // 1: divider pulses exactly at cycles 25 and 50 after release
      rst = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         tick();
         chk("clk_enable", 16'(clk_enable), (k == 25 || k == 50) ? 16'h1 : 16'h0);
      end
      chk("idle_freq1", freq1, 16'h0);
      chk("idle_pw3", 16'(pw3), 16'h0);
      chk("idle_fc", 16'(fc), 16'h0);
      chk("idle_mode_vol", 16'(mode_vol), 16'h0);
      chk("idle_sus_rel3", 16'(sus_rel3), 16'h0);

      // 2: voice-1 frequency and pulse width (pw hi upper nibble dropped)
      wr(5'h00, 8'h34);
      chk("freq1_lo", freq1, 16'h0034);
      wr(5'h01, 8'h12);
      wr(5'h03, 8'hFA);
      chk("freq1", freq1, 16'h1234);
      chk("pw1", 16'(pw1), 16'h0A00);
      chk("freq2", freq2, 16'h0);
      chk("pw2", 16'(pw2), 16'h0);
      tick();
      chk("idle_ack", 16'(bus_ack), 16'h0);

      // 3: filter cutoff split across two registers, voice-2 control
      wr(5'h15, 8'hFF);
      chk("fc_lo", 16'(fc), 16'h0007);
      wr(5'h16, 8'h80);
      chk("fc", 16'(fc), 16'h0407);
      wr(5'h0B, 8'h41);
      chk("ctrl_reg2", 16'(ctrl_reg2), 16'h41);
      chk("ctrl_reg1", 16'(ctrl_reg1), 16'h0);
      wr(5'h17, 8'hA5);
      wr(5'h18, 8'h3C);
      wr(5'h14, 8'hE1);
      chk("res_filt", 16'(res_filt), 16'hA5);
      chk("mode_vol", 16'(mode_vol), 16'h3C);
      chk("sus_rel3", 16'(sus_rel3), 16'hE1);
      chk("sus_rel2", 16'(sus_rel2), 16'h0);

      // 4: back-to-back readback of OSC3, ENV3 and POT
      osc3    = 8'h5A;
      ch3_env = 8'hC3;
      rd(5'h1B, 8'h5A, "rd_osc3");
      rd(5'h1C, 8'hC3, "rd_env3");
      rd(5'h19, 8'hFF, "rd_potx");
      rd(5'h1A, 8'hFF, "rd_poty");
      tick();
      chk("rdata_hold", 16'(bus_rdata), 16'hFF);
      chk("idle_ack2", 16'(bus_ack), 16'h0);

      // 5: bus decay, including a write in the immediately preceding cycle
      wr(5'h0E, 8'h77);
      chk("freq3", freq3, 16'h0077);
      rd(5'h04, 8'h77, "rd_decay_wo");
      rd(5'h1F, 8'h77, "rd_decay_unmapped");
      wr(5'h1C, 8'h11);
      rd(5'h1C, 8'hC3, "rd_env3_after_wr");
      rd(5'h04, 8'h11, "rd_last_write");

      // 6: simultaneous write+read acts as write only
      bus_addr  = 5'h05;
      bus_wdata = 8'h9C;
      bus_we    = 1'b1;
      bus_re    = 1'b1;
      tick();
      bus_we = 1'b0;
      bus_re = 1'b0;
      chk("wr_rd_atk_dec1", 16'(atk_dec1), 16'h9C);
      chk("wr_rd_rdata", 16'(bus_rdata), 16'h11);
      chk("wr_rd_ack", 16'(bus_ack), 16'h1);
      tick();
      chk("wr_rd_single_ack", 16'(bus_ack), 16'h0);

      // reset wins over a concurrent write
      rst       = 1'b1;
      bus_addr  = 5'h00;
      bus_wdata = 8'h55;
      bus_we    = 1'b1;
      tick();
      chk("rst_wr_freq1", freq1, 16'h0);
      chk("rst_wr_ack", 16'(bus_ack), 16'h0);
      rst    = 1'b0;
      bus_we = 1'b0;
      tick();
      chk("post_rst_freq1", freq1, 16'h0);
      chk("post_rst_ack", 16'(bus_ack), 16'h0);
      rd(5'h1F, 8'h00, "post_rst_last_write");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
